// File: rtl/fuzzy_pkg.sv
// Shared types and helpers for the fuzzy risk evaluator front end.
package fuzzy_pkg;

    localparam int BYTE_W         = 8;
    localparam int MAX_IN         = 8;
    localparam int NUM_IN_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // XOR of the first n bytes of a frame; unused upper bytes are ignored.
    function automatic logic [BYTE_W-1:0] frame_csum(
        input logic [MAX_IN*BYTE_W-1:0] bytes,
        input int unsigned              n
    );
        logic [BYTE_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < MAX_IN; i++) begin
            if (i < n) acc ^= bytes[i*BYTE_W +: BYTE_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-stage synchronizer for a single pin with rising-edge pulse output.
module pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] q;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            prev <= 1'b0;
        end else begin
            q    <= {q[STAGES-2:0], d};
            prev <= q[STAGES-1];
        end
    end

    assign rise = q[STAGES-1] & ~prev;

endmodule

// File: rtl/pin_sync_vec.sv
// Multi-stage synchronizer for a pin bus; no edge detection.
module pin_sync_vec #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) q[i] <= '0;
        end else begin
            q[0] <= d;
            for (int i = 1; i < STAGES; i++) q[i] <= q[i-1];
        end
    end

    assign q_out = q[STAGES-1];

endmodule

// File: rtl/fuzzy_frame_loader.sv
// Collects strobed pin bytes into a checksummed frame and hands the verified
// vector to the fuzzy core over valid/ready.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for the first byte of a frame
//   COLLECT | storing payload bytes, then the checksum byte; gap timer runs
//   CHECK   | one cycle to act on the checksum compare result
//   HOLD    | verified frame presented, waiting for frame_ready
module fuzzy_frame_loader
    import fuzzy_pkg::*;
#(
    parameter int NUM_IN      = NUM_IN_DEFAULT,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ss,
    input  logic [BYTE_W-1:0]          data_bus,
    output logic [NUM_IN*BYTE_W-1:0]   in_vec,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic                       err_csum,
    output logic                       err_timeout,
    output logic                       err_overrun,
    output logic                       busy
);

    localparam int CNT_W = $clog2(NUM_IN + 1);
    localparam int GAP_W = $clog2(TIMEOUT + 1);

    logic                      stb;
    logic [BYTE_W-1:0]         data_s;
    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [GAP_W-1:0]          gap;
    logic [NUM_IN*BYTE_W-1:0]  frame_buf;
    logic [MAX_IN*BYTE_W-1:0]  frame_pad;
    logic                      csum_ok;

    pin_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (ss),
        .rise (stb)
    );

    pin_sync_vec #(.STAGES(SYNC_STAGES), .WIDTH(BYTE_W)) u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (data_bus),
        .q_out (data_s)
    );

    assign frame_pad = (MAX_IN*BYTE_W)'(frame_buf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            gap         <= '0;
            frame_buf   <= '0;
            csum_ok     <= 1'b0;
            in_vec      <= '0;
            frame_valid <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            case (state)
                IDLE: begin
                    gap <= '0;
                    if (stb) begin
                        frame_buf[BYTE_W-1:0] <= data_s;
                        cnt                   <= CNT_W'(1);
                        busy                  <= 1'b1;
                        state                 <= COLLECT;
                    end
                end
                COLLECT: begin
                    // Timeout wins over a coincident strobe; that byte is lost.
                    if (gap == GAP_W'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                        gap         <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (stb) begin
                        gap <= '0;
                        if (cnt == CNT_W'(NUM_IN)) begin
                            csum_ok <= (frame_csum(frame_pad, NUM_IN) == data_s);
                            state   <= CHECK;
                        end else begin
                            frame_buf[BYTE_W*cnt +: BYTE_W] <= data_s;
                            cnt                             <= cnt + CNT_W'(1);
                        end
                    end else begin
                        gap <= gap + GAP_W'(1);
                    end
                end
                CHECK: begin
                    cnt  <= '0;
                    busy <= 1'b0;
                    if (csum_ok) begin
                        in_vec      <= frame_buf;
                        frame_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        err_csum <= 1'b1;
                        state    <= IDLE;
                    end
                end
                HOLD: begin
                    if (stb) err_overrun <= 1'b1;
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
